// File: rtl/vid_timing_pkg.sv
// Shared timing defaults, pattern encodings and colour constants
// for the synthetic video source.
package vid_timing_pkg;

    localparam int VGA_H_DISP  = 640;
    localparam int VGA_V_DISP  = 480;
    localparam int VGA_H_SYNC  = 96;
    localparam int VGA_H_BACK  = 48;
    localparam int VGA_H_FRONT = 16;
    localparam int VGA_V_SYNC  = 2;
    localparam int VGA_V_BACK  = 33;
    localparam int VGA_V_FRONT = 10;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_SOLID = 2'd2,
        PAT_LANE  = 2'd3
    } pat_e;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    localparam logic [23:0] LANE_BG = 24'h404040;
    localparam logic [23:0] LANE_FG = 24'hFFFFFF;

    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        logic [23:0] c;
        unique case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vid_pattern_gen.sv
// Combinational test-content generator: active-pixel coordinate
// plus frame-latched settings to RGB888.
module vid_pattern_gen
    import vid_timing_pkg::*;
#(
    parameter int H_DISP = VGA_H_DISP,
    parameter int V_DISP = VGA_V_DISP
) (
    input  logic [11:0] x,
    input  logic [11:0] y,
    input  pat_e        pat,
    input  logic [23:0] solid,
    input  logic [7:0]  offset,
    output logic [23:0] rgb
);

    localparam logic [11:0]        BAR_W  = 12'(H_DISP / 8);
    localparam logic [11:0]        Y_MID  = 12'(V_DISP / 2);
    localparam logic signed [13:0] HD_S   = 14'(H_DISP);
    localparam logic signed [13:0] XL0    = 14'(H_DISP / 2 - 1);
    localparam logic signed [13:0] XR0    = 14'(H_DISP / 2);

    logic [11:0]        bar_idx;
    logic signed [13:0] xs, d, off, xl, xr, dl, dr;
    logic               on_l, on_r, lower;

    always_comb begin
        bar_idx = x / BAR_W;
        xs      = $signed({2'b00, x});
        d       = $signed({2'b00, y}) - $signed({2'b00, Y_MID});
        off     = $signed({{6{offset[7]}}, offset});
        // centres may fall off-screen; they are clipped, never wrapped
        xl      = XL0 - d + off;
        xr      = XR0 + d + off;
        dl      = xs - xl;
        dr      = xs - xr;
        lower   = y >= Y_MID;
        on_l    = (xl >= 14'sd0) && (xl < HD_S)
                  && (dl >= -14'sd2) && (dl <= 14'sd1);
        on_r    = (xr >= 14'sd0) && (xr < HD_S)
                  && (dr >= -14'sd2) && (dr <= 14'sd1);
        rgb     = 24'h0;
        unique case (pat)
            PAT_BARS:  rgb = bar_rgb(bar_idx[2:0]);
            PAT_RAMP:  rgb = {3{x[9:2]}};
            PAT_SOLID: rgb = solid;
            PAT_LANE:  rgb = (lower && (on_l || on_r)) ? LANE_FG : LANE_BG;
            default:   rgb = 24'h0;
        endcase
    end

endmodule

// File: rtl/vid_stream_gen.sv
// Raster timing source: counters, run/idle FSM and registered
// sync/enable/coordinate/pixel outputs.
module vid_stream_gen
    import vid_timing_pkg::*;
#(
    parameter int   H_DISP      = VGA_H_DISP,
    parameter int   V_DISP      = VGA_V_DISP,
    parameter int   H_SYNC      = VGA_H_SYNC,
    parameter int   H_BACK      = VGA_H_BACK,
    parameter int   H_FRONT     = VGA_H_FRONT,
    parameter int   V_SYNC      = VGA_V_SYNC,
    parameter int   V_BACK      = VGA_V_BACK,
    parameter int   V_FRONT     = VGA_V_FRONT,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_rgb,
    input  logic [7:0]  lane_offset,
    output logic        img_hsync,
    output logic        img_vsync,
    output logic        img_de,
    output logic [23:0] img_data,
    output logic [11:0] x_axis,
    output logic [11:0] y_axis,
    output logic        frame_start,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_SW   = 12'(H_SYNC);
    localparam logic [11:0] V_SW   = 12'(V_SYNC);
    localparam logic [11:0] H_ACT0 = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] H_ACT1 = 12'(H_SYNC + H_BACK + H_DISP);
    localparam logic [11:0] V_ACT0 = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] V_ACT1 = 12'(V_SYNC + V_BACK + V_DISP);

    typedef enum logic {IDLE, RUN} state_e;

    state_e      state, state_nxt;
    logic [11:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic [11:0] px, py;
    logic        active, h_last, last_pix, fs, de;
    pat_e        pat_q;
    logic [23:0] solid_q, rgb;
    logic [7:0]  off_q;

    // IDLE with en set already emits pixel (0,0), so frame_start
    // appears on the clock right after en is seen.
    always_comb begin
        active    = (state == RUN) || en;
        h_last    = h_cnt == H_LAST;
        last_pix  = h_last && (v_cnt == V_LAST);
        fs        = active && (h_cnt == 12'd0) && (v_cnt == 12'd0);
        de        = (h_cnt >= H_ACT0) && (h_cnt < H_ACT1)
                    && (v_cnt >= V_ACT0) && (v_cnt < V_ACT1);
        px        = de ? h_cnt - H_ACT0 : 12'd0;
        py        = de ? v_cnt - V_ACT0 : 12'd0;
        state_nxt = state;
        h_nxt     = h_cnt;
        v_nxt     = v_cnt;
        unique case (state)
            IDLE: if (en) state_nxt = RUN;
            RUN:  if (last_pix && !en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (active) begin
            h_nxt = h_last ? 12'd0 : h_cnt + 12'd1;
            if (h_last) v_nxt = (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            h_cnt <= 12'd0;
            v_cnt <= 12'd0;
        end else begin
            state <= state_nxt;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q   <= PAT_BARS;
            solid_q <= 24'h0;
            off_q   <= 8'h0;
        end else if (fs) begin
            pat_q   <= pat_e'(pattern_sel);
            solid_q <= solid_rgb;
            off_q   <= lane_offset;
        end
    end

    vid_pattern_gen #(
        .H_DISP (H_DISP),
        .V_DISP (V_DISP)
    ) u_pat (
        .x      (px),
        .y      (py),
        .pat    (pat_q),
        .solid  (solid_q),
        .offset (off_q),
        .rgb    (rgb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            img_hsync   <= ~SYNC_ACTIVE;
            img_vsync   <= ~SYNC_ACTIVE;
            img_de      <= 1'b0;
            img_data    <= 24'h0;
            x_axis      <= 12'd0;
            y_axis      <= 12'd0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            frame_cnt   <= 16'd0;
        end else begin
            img_hsync   <= ~SYNC_ACTIVE;
            img_vsync   <= ~SYNC_ACTIVE;
            img_de      <= 1'b0;
            img_data    <= 24'h0;
            x_axis      <= 12'd0;
            y_axis      <= 12'd0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            if (active) begin
                img_hsync   <= (h_cnt < H_SW) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                img_vsync   <= (v_cnt < V_SW) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                img_de      <= de;
                img_data    <= de ? rgb : 24'h0;
                x_axis      <= px;
                y_axis      <= py;
                frame_start <= fs;
                busy        <= 1'b1;
                if (last_pix) frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vid_stream_gen.sv
// Bench for vid_stream_gen on a reduced raster, checked every cycle
// against a position-indexed behavioural model.
module tb_vid_stream_gen;

    localparam int HD = 64, VD = 16;
    localparam int HS = 4, HB = 3, HF = 2;
    localparam int VS = 2, VB = 3, VF = 2;
    localparam int HT = HS + HB + HD + HF;
    localparam int VT = VS + VB + VD + VF;
    localparam int FT = HT * VT;
    localparam int HA = HS + HB;
    localparam int VA = VS + VB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [23:0] solid_rgb = 24'h0;
    logic [7:0]  lane_offset = 8'h0;
    logic        img_hsync, img_vsync, img_de, frame_start, busy;
    logic [23:0] img_data;
    logic [11:0] x_axis, y_axis;
    logic [15:0] frame_cnt;

    int n_chk = 0;
    int n_fail = 0;

    vid_stream_gen #(
        .H_DISP(HD), .V_DISP(VD), .H_SYNC(HS), .H_BACK(HB),
        .H_FRONT(HF), .V_SYNC(VS), .V_BACK(VB), .V_FRONT(VF),
        .SYNC_ACTIVE(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel),
        .solid_rgb(solid_rgb), .lane_offset(lane_offset),
        .img_hsync(img_hsync), .img_vsync(img_vsync), .img_de(img_de),
        .img_data(img_data), .x_axis(x_axis), .y_axis(y_axis),
        .frame_start(frame_start), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp,
                     $time);
        end
    endtask

    function automatic logic [23:0] ref_rgb(input int x, input int y,
                                            input int pat,
                                            input logic [23:0] sol,
                                            input int off);
        logic [23:0] bars [8];
        int d, xl, xr;
        bit w;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        case (pat)
            0: return bars[x / (HD / 8)];
            1: return {3{8'((x >> 2) & 255)}};
            2: return sol;
            default: begin
                w = 0;
                if (y >= VD / 2) begin
                    d  = y - VD / 2;
                    xl = HD / 2 - 1 - d + off;
                    xr = HD / 2 + d + off;
                    if (xl >= 0 && xl < HD && x >= xl - 2 && x <= xl + 1) w = 1;
                    if (xr >= 0 && xr < HD && x >= xr - 2 && x <= xr + 1) w = 1;
                end
                return w ? 24'hFFFFFF : 24'h404040;
            end
        endcase
    endfunction

    // model: one linear position per frame, h/v derived by div/mod
    int          m_pos = 0, m_fcnt = 0, m_lpat = 0, m_loff = 0;
    bit          m_run = 0;
    logic [23:0] m_lsol = 24'h0;
    int          mh, mv, ex, ey;
    logic        e_hs, e_vs, e_de, e_fs, e_busy;
    logic [23:0] e_data;
    logic [68:0] got_v, exp_v;

    always @(posedge clk or posedge rst) begin
        e_hs = 1; e_vs = 1; e_de = 0; e_data = 0; ex = 0; ey = 0;
        e_fs = 0; e_busy = 0;
        if (rst) begin
            m_run = 0; m_pos = 0; m_fcnt = 0;
        end else if (m_run || en) begin
            mh = m_pos % HT;
            mv = m_pos / HT;
            if (m_pos == 0) begin
                m_lpat = int'(pattern_sel);
                m_lsol = solid_rgb;
                m_loff = int'($signed(lane_offset));
            end
            e_hs   = !(mh < HS);
            e_vs   = !(mv < VS);
            e_de   = mh >= HA && mh < HA + HD && mv >= VA && mv < VA + VD;
            ex     = e_de ? mh - HA : 0;
            ey     = e_de ? mv - VA : 0;
            e_data = e_de ? ref_rgb(ex, ey, m_lpat, m_lsol, m_loff) : 24'h0;
            e_fs   = m_pos == 0;
            e_busy = 1;
            if (m_pos == FT - 1) begin
                m_fcnt = (m_fcnt + 1) % 65536;
                m_pos = 0;
                m_run = en;
            end else begin
                m_pos++;
                m_run = 1;
            end
        end
        #1;
        got_v = {img_hsync, img_vsync, img_de, img_data, x_axis, y_axis,
                 frame_start, busy, frame_cnt};
        exp_v = {e_hs, e_vs, e_de, e_data, 12'(ex), 12'(ey), e_fs, e_busy,
                 16'(m_fcnt)};
        n_chk++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL cycle: got %h expected %h at %0t", got_v, exp_v,
                     $time);
        end
        if (e_de && m_lpat == 0 && ey == 3) begin
            if (ex == 0)  chk("bars_x0", 32'(img_data), 32'hFFFFFF);
            if (ex == 7)  chk("bars_x7", 32'(img_data), 32'hFFFFFF);
            if (ex == 8)  chk("bars_x8", 32'(img_data), 32'hFFFF00);
            if (ex == 63) chk("bars_x63", 32'(img_data), 32'h000000);
        end
        if (e_de && m_lpat == 3 && m_loff == 0) begin
            if (ey == 8 && ex == 30)  chk("lane_y8_x30", 32'(img_data), 32'hFFFFFF);
            if (ey == 8 && ex == 33)  chk("lane_y8_x33", 32'(img_data), 32'hFFFFFF);
            if (ey == 8 && ex == 28)  chk("lane_y8_x28", 32'(img_data), 32'h404040);
            if (ey == 12 && ex == 27) chk("lane_y12_xl", 32'(img_data), 32'hFFFFFF);
            if (ey == 12 && ex == 36) chk("lane_y12_xr", 32'(img_data), 32'hFFFFFF);
            if (ey == 12 && ex == 31) chk("lane_y12_mid", 32'(img_data), 32'h404040);
            if (ey == 7 && ex == 31)  chk("lane_y7_none", 32'(img_data), 32'h404040);
        end
        if (e_de && m_lpat == 3 && m_loff == -20 && ey == 8) begin
            if (ex == 9)  chk("lane_m20_x9", 32'(img_data), 32'hFFFFFF);
            if (ex == 13) chk("lane_m20_x13", 32'(img_data), 32'hFFFFFF);
            if (ex == 8)  chk("lane_m20_x8", 32'(img_data), 32'h404040);
            if (ex == 14) chk("lane_m20_x14", 32'(img_data), 32'h404040);
        end
    end

    task automatic wait_fs(input string name);
        int i;
        for (i = 0; i < 2 * FT && !frame_start; i++) @(negedge clk);
        if (!frame_start) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    int de_n, per, fc0;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_hsync", 32'(img_hsync), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        chk("first_fs", 32'(frame_start), 32'd1);
        @(negedge clk);
        // one full frame period: de count and frame_start spacing
        wait_fs("meas_a");
        de_n = 0;
        per = 0;
        for (int i = 0; i < 2 * FT; i++) begin
            @(negedge clk);
            per++;
            if (img_de) de_n++;
            if (frame_start) break;
        end
        chk("frame_period", 32'(per), 32'(FT));
        chk("de_per_frame", 32'(de_n), 32'(HD * VD));

        pattern_sel = 2'd3;
        lane_offset = 8'd0;
        repeat (2 * FT) @(negedge clk);
        wait_fs("lane_mid");
        repeat (FT / 3) @(negedge clk);
        lane_offset = 8'hEC;
        repeat (2 * FT) @(negedge clk);

        pattern_sel = 2'd1;
        repeat (FT + 50) @(negedge clk);
        pattern_sel = 2'd2;
        solid_rgb = 24'($urandom);
        repeat (FT + 50) @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(100, FT)) @(negedge clk);
            pattern_sel = 2'($urandom_range(0, 3));
            solid_rgb = 24'($urandom);
            lane_offset = ($urandom_range(0, 1) == 1) ?
                          8'($urandom) : 8'($urandom_range(0, 80) - 40);
            if ($urandom_range(0, 2) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(1, FT)) @(negedge clk);
                en = 1'b1;
            end
        end

        wait_fs("drop");
        repeat (5 * HT) @(negedge clk);
        fc0 = int'(frame_cnt);
        en = 1'b0;
        for (int i = 0; i < 2 * FT && busy; i++) @(negedge clk);
        chk("drop_busy", 32'(busy), 32'd0);
        chk("drop_fcnt", 32'(frame_cnt), 32'((fc0 + 1) % 65536));
        chk("drop_de", 32'(img_de), 32'd0);
        repeat (10) @(negedge clk);
        chk("idle_vsync", 32'(img_vsync), 32'd1);
        en = 1'b1;
        @(negedge clk);
        chk("reen_fs", 32'(frame_start), 32'd1);

        repeat (HT * 8 + 20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_data", 32'(img_data), 32'd0);
        chk("arst_x", 32'(x_axis), 32'd0);
        chk("arst_hsync", 32'(img_hsync), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_fs", 32'(frame_start), 32'd1);
        repeat (FT + 20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
